// File: rtl/soc_bus_arbiter_pkg.sv
// ============================================================================
// soc_bus_pkg : shared types and constants for the SoC bus arbiter slice
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`ifndef XLEN
`define XLEN 32
`endif

package soc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int NUM_SLV   = 3;
  localparam int SLV_DMEM  = 0;
  localparam int SLV_CLINT = 1;
  localparam int SLV_UART  = 2;

  localparam logic [31:0] DMEM_BASE_DEF  = 32'h8000_0000;
  localparam int unsigned DMEM_SIZE_DEF  = 16384;
  localparam logic [31:0] CLINT_BASE_DEF = 32'h0200_0000;
  localparam int unsigned CLINT_SIZE     = 32'h0001_0000;
  localparam logic [31:0] UART_BASE_DEF  = 32'h1000_0000;
  localparam int unsigned UART_SIZE      = 8;
  localparam int unsigned TIMEOUT_DEF    = 255;

endpackage

`default_nettype wire

// File: rtl/soc_bus_arbiter_if.sv
// ============================================================================
// soc_bus_arbiter_if : two-master request/response bus plus three-slave bus
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`ifndef XLEN
`define XLEN 32
`endif

interface soc_bus_arbiter_if #(
  parameter int XLEN = `XLEN
);
  logic            m0_req_valid, m1_req_valid;
  logic [XLEN-1:0] m0_req_addr,  m1_req_addr;
  logic [63:0]     m0_req_wdata, m1_req_wdata;
  logic            m0_req_we,    m1_req_we;
  logic [2:0]      m0_req_size,  m1_req_size;
  logic            m0_req_ready, m1_req_ready;
  logic            m0_resp_valid, m1_resp_valid;
  logic [63:0]     m0_resp_rdata, m1_resp_rdata;
  logic            m0_resp_err,   m1_resp_err;

  logic [2:0]      s_req_valid;
  logic [XLEN-1:0] s_req_addr;
  logic [63:0]     s_req_wdata;
  logic            s_req_we;
  logic [2:0]      s_req_size;
  logic [2:0]      s_req_ready;
  logic [191:0]    s_rdata;

  // Arbiter side
  modport slave (
    input  m0_req_valid, m0_req_addr, m0_req_wdata, m0_req_we, m0_req_size,
    input  m1_req_valid, m1_req_addr, m1_req_wdata, m1_req_we, m1_req_size,
    output m0_req_ready, m0_resp_valid, m0_resp_rdata, m0_resp_err,
    output m1_req_ready, m1_resp_valid, m1_resp_rdata, m1_resp_err,
    output s_req_valid, s_req_addr, s_req_wdata, s_req_we, s_req_size,
    input  s_req_ready, s_rdata
  );

  // Environment side: the two masters and the three slaves
  modport master (
    output m0_req_valid, m0_req_addr, m0_req_wdata, m0_req_we, m0_req_size,
    output m1_req_valid, m1_req_addr, m1_req_wdata, m1_req_we, m1_req_size,
    input  m0_req_ready, m0_resp_valid, m0_resp_rdata, m0_resp_err,
    input  m1_req_ready, m1_resp_valid, m1_resp_rdata, m1_resp_err,
    input  s_req_valid, s_req_addr, s_req_wdata, s_req_we, s_req_size,
    output s_req_ready, s_rdata
  );
endinterface

`default_nettype wire

// File: rtl/soc_bus_arbiter_addr_decode.sv
// ============================================================================
// bus_addr_decode : combinational address -> one-hot slave hit and offset
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`ifndef XLEN
`define XLEN 32
`endif

module bus_addr_decode
  import soc_bus_pkg::*;
#(
  parameter int              XLEN       = `XLEN,
  parameter logic [XLEN-1:0] DMEM_BASE  = DMEM_BASE_DEF,
  parameter int unsigned     DMEM_SIZE  = DMEM_SIZE_DEF,
  parameter logic [XLEN-1:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [XLEN-1:0] UART_BASE  = UART_BASE_DEF
) (
  input  logic [XLEN-1:0]    addr_i,
  output logic [NUM_SLV-1:0] hit_o,
  output logic [XLEN-1:0]    offset_o
);

  logic [XLEN-1:0] w_off [NUM_SLV];

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_slv
    localparam logic [XLEN-1:0] c_base =
        (i == SLV_DMEM)  ? DMEM_BASE  :
        (i == SLV_CLINT) ? CLINT_BASE : UART_BASE;
    localparam logic [XLEN-1:0] c_size =
        (i == SLV_DMEM)  ? XLEN'(DMEM_SIZE)  :
        (i == SLV_CLINT) ? XLEN'(CLINT_SIZE) : XLEN'(UART_SIZE);

    // The lower-bound test keeps a wrapped subtraction from aliasing a hit
    assign w_off[i] = addr_i - c_base;
    assign hit_o[i] = (addr_i >= c_base) && (w_off[i] < c_size);
  end

  always_comb begin
    offset_o = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (hit_o[i]) offset_o = w_off[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/soc_bus_arbiter.sv
// ============================================================================
// soc_bus_arbiter : round-robin two-master to three-slave single-outstanding bus
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`ifndef XLEN
`define XLEN 32
`endif

module soc_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int              XLEN       = `XLEN,
  parameter logic [XLEN-1:0] DMEM_BASE  = DMEM_BASE_DEF,
  parameter int unsigned     DMEM_SIZE  = DMEM_SIZE_DEF,
  parameter logic [XLEN-1:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [XLEN-1:0] UART_BASE  = UART_BASE_DEF,
  parameter int unsigned     TIMEOUT    = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  soc_bus_arbiter_if.slave bus
);

  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                win_q, win_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [63:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [2:0]          size_q, size_d;
  logic [NUM_SLV-1:0]  hit_q, hit_d;
  logic [63:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [7:0]          cnt_q, cnt_d;

  logic [1:0]          w_valid;
  logic                w_win;
  logic                w_accept;
  logic [XLEN-1:0]     w_win_addr;
  logic [NUM_SLV-1:0]  w_hit;
  logic [XLEN-1:0]     w_off;
  logic                w_sel_ready;
  logic [63:0]         w_sel_rdata;

  assign w_valid    = {bus.m1_req_valid, bus.m0_req_valid};
  // On a tie the master that did not win last time goes next
  assign w_win      = (&w_valid) ? ~last_q : w_valid[1];
  assign w_accept   = (state_q == IDLE) && (|w_valid) && !reset;
  assign w_win_addr = w_win ? bus.m1_req_addr : bus.m0_req_addr;

  bus_addr_decode #(
    .XLEN      (XLEN),
    .DMEM_BASE (DMEM_BASE),
    .DMEM_SIZE (DMEM_SIZE),
    .CLINT_BASE(CLINT_BASE),
    .UART_BASE (UART_BASE)
  ) u_decode (
    .addr_i  (w_win_addr),
    .hit_o   (w_hit),
    .offset_o(w_off)
  );

  assign w_sel_ready = |(bus.s_req_ready & hit_q);

  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (hit_q[i]) w_sel_rdata = bus.s_rdata[64*i +: 64];
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    size_d  = size_q;
    hit_d   = hit_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          win_d   = w_win;
          last_d  = w_win;
          addr_d  = w_off;
          wdata_d = w_win ? bus.m1_req_wdata : bus.m0_req_wdata;
          we_d    = w_win ? bus.m1_req_we    : bus.m0_req_we;
          size_d  = w_win ? bus.m1_req_size  : bus.m0_req_size;
          hit_d   = w_hit;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = ~(|w_hit);
          state_d = (|w_hit) ? REQ : RESP;
        end
      end
      REQ: begin
        if (w_sel_ready) begin
          rdata_d = we_q ? 64'd0 : w_sel_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == c_timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      hit_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      size_q  <= size_d;
      hit_q   <= hit_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.m0_req_ready  = w_accept && !w_win;
  assign bus.m1_req_ready  = w_accept &&  w_win;
  assign bus.m0_resp_valid = (state_q == RESP) && !win_q;
  assign bus.m1_resp_valid = (state_q == RESP) &&  win_q;
  assign bus.m0_resp_rdata = bus.m0_resp_valid ? rdata_q : 64'd0;
  assign bus.m1_resp_rdata = bus.m1_resp_valid ? rdata_q : 64'd0;
  assign bus.m0_resp_err   = bus.m0_resp_valid && err_q;
  assign bus.m1_resp_err   = bus.m1_resp_valid && err_q;

  assign bus.s_req_valid = (state_q == REQ) ? hit_q : '0;
  assign bus.s_req_addr  = addr_q;
  assign bus.s_req_wdata = wdata_q;
  assign bus.s_req_we    = we_q;
  assign bus.s_req_size  = size_q;

endmodule

`default_nettype wire
